// File: rtl/ec_point_encoder_if.sv
// ec_point_encoder_if: point-in / byte-out stream bundle for the SEC1 point encoder
interface ec_point_encoder_if #(
    parameter int MAX_COORD_BYTES = 66,
    parameter int LEN_W           = 7
);
    logic                           in_valid;
    logic                           in_ready;
    logic [8*MAX_COORD_BYTES-1:0]   in_x;
    logic [8*MAX_COORD_BYTES-1:0]   in_y;
    logic                           in_inf;
    logic                           in_compressed;
    logic [LEN_W-1:0]               coord_len;
    logic                           out_valid;
    logic [7:0]                     out_data;
    logic                           out_last;
    logic                           out_ready;
    logic                           err;
    logic                           busy;

    modport master (
        output in_valid, in_x, in_y, in_inf, in_compressed, coord_len, out_ready,
        input  in_ready, out_valid, out_data, out_last, err, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_inf, in_compressed, coord_len, out_ready,
        output in_ready, out_valid, out_data, out_last, err, busy
    );
endinterface

// File: rtl/ec_point_encoder.sv
// ec_point_encoder: serialises an affine EC point as a SEC1 octet string on a byte stream
module ec_point_encoder #(
    parameter int MAX_COORD_BYTES = 66,
    parameter int LEN_W           = 7
) (
    input  logic               clk,
    input  logic               rst,
    ec_point_encoder_if.slave  bus
);
    localparam int W = 8 * MAX_COORD_BYTES;

    typedef enum logic [2:0] {IDLE, CHECK, HDR, XB, YB} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic             inf_q, inf_d, comp_q, comp_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
    logic [LEN_W+2:0] sh;
    logic             bad, hs_in, hs_out;

    // state and latched point registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            inf_q   <= 1'b0;
            comp_q  <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            inf_q   <= inf_d;
            comp_q  <= comp_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // next-state, byte selection and validity checks of the latched point
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        inf_d         = inf_q;
        comp_d        = comp_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sh            = {len_q, 3'b000};
        bad           = (len_q == '0) || (len_q > LEN_W'(MAX_COORD_BYTES)) ||
                        (!inf_q && ((|(x_q >> sh)) || (!comp_q && (|(y_q >> sh)))));
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == HDR) || (state_q == XB) || (state_q == YB);
        bus.out_data  = 8'h00;
        bus.out_last  = 1'b0;
        bus.err       = 1'b0;
        bus.busy      = state_q != IDLE;
        hs_in         = bus.in_valid && bus.in_ready;
        hs_out        = bus.out_valid && bus.out_ready;
        case (state_q)
            IDLE: begin
                if (hs_in) begin
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    inf_d   = bus.in_inf;
                    comp_d  = bus.in_compressed;
                    len_d   = bus.coord_len;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                bus.err = bad;
                state_d = bad ? IDLE : HDR;
            end
            HDR: begin
                bus.out_data = inf_q ? 8'h00 : comp_q ? {7'b0000001, y_q[0]} : 8'h04;
                bus.out_last = inf_q;
                if (hs_out) begin
                    state_d = inf_q ? IDLE : XB;
                    idx_d   = len_q - 1'b1;
                end
            end
            XB: begin
                bus.out_data = x_q[{idx_q, 3'b000} +: 8];
                bus.out_last = comp_q && (idx_q == '0);
                if (hs_out) begin
                    state_d = (idx_q != '0) ? XB : comp_q ? IDLE : YB;
                    idx_d   = (idx_q != '0) ? idx_q - 1'b1 : len_q - 1'b1;
                end
            end
            YB: begin
                bus.out_data = y_q[{idx_q, 3'b000} +: 8];
                bus.out_last = idx_q == '0;
                if (hs_out) begin
                    state_d = (idx_q != '0) ? YB : IDLE;
                    idx_d   = (idx_q != '0) ? idx_q - 1'b1 : idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ec_point_encoder.sv
// tb_ec_point_encoder: randomized scoreboard bench for the SEC1 point encoder
module tb_ec_point_encoder;
    localparam int MB = 66;
    localparam int W  = 8 * MB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ec_point_encoder_if #(.MAX_COORD_BYTES(MB), .LEN_W(7)) bus();
    ec_point_encoder #(.MAX_COORD_BYTES(MB), .LEN_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         hs_cnt = 0;
    bit         bp = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] rand_coord(int len);
        logic [W-1:0] v = '0;
        for (int i = 0; i < len; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    function automatic bit is_bad(logic [W-1:0] x, logic [W-1:0] y, logic inf, logic comp, int len);
        if (len < 1 || len > MB) return 1'b1;
        if (inf) return 1'b0;
        if ((x >> (8*len)) != '0) return 1'b1;
        return !comp && ((y >> (8*len)) != '0);
    endfunction

    function automatic void push_frame(logic [W-1:0] x, logic [W-1:0] y, logic inf, logic comp, int len);
        if (inf) begin
            exp_q.push_back({1'b1, 8'h00});
            return;
        end
        exp_q.push_back({1'b0, comp ? (y[0] ? 8'h03 : 8'h02) : 8'h04});
        for (int i = len - 1; i >= 0; i--) exp_q.push_back({comp && i == 0, x[8*i +: 8]});
        if (!comp)
            for (int i = len - 1; i >= 0; i--) exp_q.push_back({i == 0, y[8*i +: 8]});
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: pops the scoreboard on every output handshake and polices stream rules
    initial begin
        bit         stall = 1'b0;
        bit         last_hs = 1'b0;
        logic [8:0] prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                last_hs = 1'b0;
            end else begin
                if (stall) chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, prev});
                if (last_hs) chk("idle_after_last", {bus.in_ready, bus.busy}, 2'b10);
                last_hs = 1'b0;
                stall = bus.out_valid && !bus.out_ready;
                prev = {bus.out_last, bus.out_data};
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %0h expected none", {bus.out_last, bus.out_data});
                    end else chk("byte", {bus.out_last, bus.out_data}, exp_q.pop_front());
                    last_hs = bus.out_last;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic inf,
                        input logic comp, input int len, input string tag, input bit drain);
        bit bad = is_bad(x, y, inf, comp, len);
        int t = 0;
        if (!bad) push_frame(x, y, inf, comp, len);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_inf = inf;
        bus.in_compressed = comp;
        bus.coord_len = 7'(len);
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: got in_ready=0 expected 1 within 50 cycles", tag);
            bus.in_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x = rand_coord(MB);
        bus.in_y = rand_coord(MB);
        bus.in_inf = 1'($urandom);
        bus.in_compressed = 1'($urandom);
        bus.coord_len = 7'($urandom);
        @(negedge clk);
        chk({tag, "_t1"}, {bus.err, bus.out_valid}, {bad, 1'b0});
        @(negedge clk);
        if (bad) chk({tag, "_t2"}, {bus.err, bus.out_valid, bus.in_ready}, 3'b001);
        else chk({tag, "_t2"}, {bus.out_valid, bus.err}, 2'b10);
        if (!bad && drain) begin
            t = 0;
            while (exp_q.size() != 0 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_drain: got %0d bytes left expected 0", tag, exp_q.size());
                exp_q.delete();
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_busy"}, bus.busy, 1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y;
        int           len, t, base;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_inf = 1'b0;
        bus.in_compressed = 1'b0;
        bus.coord_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.out_last, bus.err, bus.busy, bus.out_data}, 13'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {bus.in_ready, bus.busy}, 2'b10);

        send(W'(1), W'(2), 1'b0, 1'b0, 32, "p256_unc", 1'b1);
        y = rand_coord(32);
        y[0] = 1'b1;
        send(W'(8'hAB), y, 1'b0, 1'b1, 32, "comp_odd", 1'b1);
        y[0] = 1'b0;
        send(W'(8'hAB), y, 1'b0, 1'b1, 32, "comp_even", 1'b1);
        send(rand_coord(MB), rand_coord(MB), 1'b1, 1'($urandom), 32, "inf", 1'b1);

        bp = 1'b1;
        send(rand_coord(48), rand_coord(48), 1'b0, 1'b0, 48, "p384_bp", 1'b1);
        bp = 1'b0;

        x = '0;
        x[256] = 1'b1;
        send(x, W'(2), 1'b0, 1'b0, 32, "err_xbit", 1'b1);
        send(W'(1), W'(2), 1'b0, 1'b0, 0, "err_len0", 1'b1);
        send(W'(1), W'(2), 1'b1, 1'b0, 67, "err_len67", 1'b1);

        base = hs_cnt;
        send(rand_coord(66), rand_coord(66), 1'b0, 1'b0, 66, "p521_cut", 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (hs_cnt - base < 10 && t < 500);
        chk("cut_hs10", hs_cnt - base, 10);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cut_reset", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        send(rand_coord(66), rand_coord(66), 1'b0, 1'b0, 66, "p521_full", 1'b1);

        for (int k = 0; k < 16; k++) begin
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 67 : 0) : $urandom_range(1, MB);
            x = rand_coord(len > MB ? MB : len);
            y = rand_coord(len > MB ? MB : len);
            if (len > 0 && len < MB && $urandom_range(0, 7) == 0) x[8*len + $urandom_range(0, 7)] = 1'b1;
            if (len > 0 && len < MB && $urandom_range(0, 7) == 0) y[8*len + $urandom_range(0, 7)] = 1'b1;
            bp = 1'($urandom);
            send(x, y, $urandom_range(0, 7) == 0, 1'($urandom), len, "rand", 1'b1);
        end
        bp = 1'b0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ec_point_encoder.md
Name: ec_point_encoder

Overview:
Downstream stage of the EC scalar-multiplication core. It takes one affine public point (X, Y) plus flags and serialises it as a SEC1 octet string on a byte-wide valid/ready stream. Output forms are uncompressed (0x04||X||Y), compressed (0x02/0x03||X) or point-at-infinity (0x00). Each coordinate is big-endian and left-padded with zero bytes to the runtime curve size. The block feeds the public-key byte buffer and the encoded-pubkey export path.

Parameters:
MAX_COORD_BYTES, 66, largest supported coordinate size in bytes (P-521); sets coordinate port width W = 8*MAX_COORD_BYTES.
LEN_W, 7, width of coord_len; must satisfy 2^LEN_W > MAX_COORD_BYTES.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset; synchronous and active-high.
in_valid  in  1  point available.
in_ready  out  1  block accepts a point (IDLE only).
in_x  in  W  X coordinate, right-aligned (LSB at bit 0).
in_y  in  W  Y coordinate, right-aligned.
in_inf  in  1  point at infinity; in_x, in_y and in_compressed are ignored.
in_compressed  in  1  1 selects compressed form, 0 selects uncompressed.
coord_len  in  LEN_W  coordinate byte length (32, 48, 66, ...); legal range 1..MAX_COORD_BYTES.
out_valid  out  1  output byte valid.
out_data  out  8  output byte.
out_last  out  1  final byte of the encoding.
out_ready  in  1  consumer accepts the byte.
err  out  1  one-cycle pulse; input point rejected.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - out_valid, out_last, err and busy are 0; out_data is 0x00.
  - in_ready is 0 while rst is high and 1 from the first cycle after rst falls.
  - An in-progress frame is abandoned with no trailing bytes.
- States: IDLE, CHECK, HDR, XB, YB.
- IDLE:
  - in_ready=1.
  - The handshake in_valid&in_ready at edge T latches in_x, in_y, in_inf, in_compressed and coord_len, then moves to CHECK.
- CHECK (cycle T+1, out_valid=0):
  - Flags an error if coord_len==0, coord_len>MAX_COORD_BYTES, or any nonzero bit of X at or above bit 8*coord_len.
  - For uncompressed non-infinity points, nonzero Y bits at or above bit 8*coord_len are also an error.
  - These checks are skipped when in_inf=1, except the coord_len range check, which always applies.
  - On error: err=1 for this cycle only, next state IDLE, no bytes emitted.
  - Otherwise: next state HDR.
- HDR (first out_valid at cycle T+2):
  - out_data is 0x00 if inf, 0x02|Y[0] if compressed, 0x04 otherwise.
  - out_last=1 only when inf.
  - On the handshake: inf goes to IDLE; otherwise go to XB with byte index i = coord_len-1.
- XB:
  - out_data = X[8i+7:8i]; i decrements on each handshake.
  - At i==0: compressed goes to IDLE with out_last=1 on that byte; uncompressed goes to YB with i = coord_len-1.
- YB:
  - out_data = Y[8i+7:8i].
  - out_last=1 at i==0; the handshake on that byte goes to IDLE.
- Frame lengths: inf = 1 byte; compressed = 1+L bytes; uncompressed = 1+2L bytes (L = latched coord_len).
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays 1.
  - out_valid never drops without a handshake, except on reset.
  - One byte per cycle at full throughput when out_ready=1.
- Back-to-back points: after the last-byte handshake, in_ready returns high the following cycle (IDLE). There is no same-cycle overlap.
- Inputs are sampled only at the IDLE handshake; later changes on in_* and coord_len have no effect on the current frame.
- The index counter never underflows: transitions are taken at i==0.

Test Plan:
- P-256 uncompressed, coord_len=32, X=1, Y=2, out_ready=1:
  - out_valid rises 2 cycles after accept.
  - Bytes: 0x04, 31×0x00, 0x01, 31×0x00, 0x02; 65 bytes total, out_last only on byte 65, in_ready high the next cycle.
- Compressed, coord_len=32, X=0xAB, Y=0x…05 (odd): bytes 0x03, 31×0x00, 0xAB; 33 bytes, out_last on byte 33. Repeat with even Y: header 0x02.
- in_inf=1 with random X/Y: exactly one byte 0x00 with out_last=1; busy returns to 0 after the handshake.
- Backpressure:
  - P-384 uncompressed (coord_len=48) with out_ready randomly toggled (~50%).
  - All 97 bytes match the reference encoding, none dropped or duplicated, and out_data is stable during every stall.
- Error cases, each producing a one-cycle err pulse at T+1, zero out_valid, and in_ready=1 at T+2:
  - coord_len=32 with X bit 256 set.
  - coord_len=0.
  - coord_len=67.
- Reset mid-frame (P-521, coord_len=66):
  - Assert rst after the 10th byte handshake; out_valid=0 the next cycle.
  - A following point encodes a full 133-byte frame that starts with 0x04.
